// File: rtl/interp_tile_scanner_if.sv
// interp_tile_scanner_if: scanner control, interpolator and pixel-stream signals; bbox inputs exist only with INTERP_SCAN_BBOX_EN
interface interp_tile_scanner_if;
  logic        start, abort, busy, setup, done;
  logic [11:0] tile_x, tile_y, x_ps, y_ps, pix_x, pix_y;
  logic [63:0] interp_in, pix_z;
  logic        pix_valid, pix_ready, pix_last;
`ifdef INTERP_SCAN_BBOX_EN
  logic [11:0] bbox_x0, bbox_x1, bbox_y0, bbox_y1;
`endif
  modport master (
    input  start, abort, tile_x, tile_y, interp_in, pix_ready,
`ifdef INTERP_SCAN_BBOX_EN
    input  bbox_x0, bbox_x1, bbox_y0, bbox_y1,
`endif
    output busy, setup, x_ps, y_ps, pix_valid, pix_x, pix_y, pix_z, pix_last, done
  );
  modport slave (
    output start, abort, tile_x, tile_y, interp_in, pix_ready,
`ifdef INTERP_SCAN_BBOX_EN
    output bbox_x0, bbox_x1, bbox_y0, bbox_y1,
`endif
    input  busy, setup, x_ps, y_ps, pix_valid, pix_x, pix_y, pix_z, pix_last, done
  );
endinterface

// File: rtl/interp_tile_scanner.sv
// interp_tile_scanner: sequences the plane interpolator over one tile in raster order into a valid/ready pixel stage.
// INTERP_SCAN_BBOX_EN clips the scan to the intersection of the tile and an inclusive absolute bounding box.
module interp_tile_scanner #(
  parameter int TILE_W       = 32,
  parameter int TILE_H       = 32,
  parameter int SETUP_CYCLES = 4
) (
  input logic                   clock_i,
  input logic                   reset_n_i,
  interp_tile_scanner_if.master scan
);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [11:0]   ox_q, ox_d, oy_q, oy_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d, x_ps, y_ps;
  logic [XW-1:0] cx_q, cx_d, xlo, xhi, xlo_n;
  logic [YW-1:0] cy_q, cy_d, ylo, yhi, ylo_n;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [63:0]   pix_z_q, pix_z_d;
  logic          setup_q, setup_d, valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic          empty, at_xhi, at_last, advance;
`ifdef INTERP_SCAN_BBOX_EN
  // Intersection is taken on unwrapped 13-bit coordinates, then stored tile-relative.
  logic [XW-1:0] xlo_q, xhi_q;
  logic [YW-1:0] ylo_q, yhi_q;
  logic          empty_q;
  logic [12:0]   tx0, tx1, ty0, ty1, lx, hx, ly, hy;
  assign tx0 = {1'b0, scan.tile_x};
  assign ty0 = {1'b0, scan.tile_y};
  assign tx1 = tx0 + 13'(TILE_W - 1);
  assign ty1 = ty0 + 13'(TILE_H - 1);
  assign lx = {1'b0, scan.bbox_x0} > tx0 ? {1'b0, scan.bbox_x0} : tx0;
  assign hx = {1'b0, scan.bbox_x1} < tx1 ? {1'b0, scan.bbox_x1} : tx1;
  assign ly = {1'b0, scan.bbox_y0} > ty0 ? {1'b0, scan.bbox_y0} : ty0;
  assign hy = {1'b0, scan.bbox_y1} < ty1 ? {1'b0, scan.bbox_y1} : ty1;
  assign xlo_n = XW'(lx - tx0);
  assign ylo_n = YW'(ly - ty0);
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      xlo_q   <= '0;
      xhi_q   <= '0;
      ylo_q   <= '0;
      yhi_q   <= '0;
      empty_q <= 1'b0;
    end else if (state_q == IDLE && scan.start) begin
      xlo_q   <= xlo_n;
      xhi_q   <= XW'(hx - tx0);
      ylo_q   <= ylo_n;
      yhi_q   <= YW'(hy - ty0);
      empty_q <= lx > hx || ly > hy;
    end
  end
  assign xlo   = xlo_q;
  assign xhi   = xhi_q;
  assign ylo   = ylo_q;
  assign yhi   = yhi_q;
  assign empty = empty_q;
`else
  assign xlo_n = '0;
  assign ylo_n = '0;
  assign xlo   = '0;
  assign ylo   = '0;
  assign xhi   = XW'(TILE_W - 1);
  assign yhi   = YW'(TILE_H - 1);
  assign empty = 1'b0;
`endif
  assign x_ps    = ox_q + 12'(cx_q);
  assign y_ps    = oy_q + 12'(cy_q);
  assign at_xhi  = cx_q == xhi;
  assign at_last = at_xhi && cy_q == yhi;
  assign advance = state_q == SCAN && (!valid_q || scan.pix_ready);
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    scnt_d  = scnt_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    pix_z_d = pix_z_q;
    valid_d = valid_q;
    last_d  = last_q;
    setup_d = 1'b0;
    done_d  = 1'b0;
    if (state_q != IDLE && scan.abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (scan.start) begin
          state_d = SETUP;
          ox_d    = scan.tile_x;
          oy_d    = scan.tile_y;
          cx_d    = xlo_n;
          cy_d    = ylo_n;
          scnt_d  = '0;
          setup_d = 1'b1;
        end
        SETUP: if (scnt_q == SW'(SETUP_CYCLES - 1)) begin
          state_d = empty ? IDLE : SCAN;
          done_d  = empty;
        end else scnt_d = scnt_q + 1'b1;
        SCAN: if (advance) begin
          pix_x_d = x_ps;
          pix_y_d = y_ps;
          pix_z_d = scan.interp_in;
          valid_d = 1'b1;
          last_d  = at_last;
          cx_d    = at_xhi ? xlo : cx_q + 1'b1;
          cy_d    = at_xhi ? cy_q + 1'b1 : cy_q;
          state_d = at_last ? FLUSH : SCAN;
        end
        FLUSH: if (valid_q && scan.pix_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      scnt_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      pix_z_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      setup_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      scnt_q  <= scnt_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      pix_z_q <= pix_z_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      setup_q <= setup_d;
      done_q  <= done_d;
    end
  end
  assign scan.busy      = state_q != IDLE;
  assign scan.setup     = setup_q;
  assign scan.x_ps      = x_ps;
  assign scan.y_ps      = y_ps;
  assign scan.pix_valid = valid_q;
  assign scan.pix_x     = pix_x_q;
  assign scan.pix_y     = pix_y_q;
  assign scan.pix_z     = pix_z_q;
  assign scan.pix_last  = last_q;
  assign scan.done      = done_q;
endmodule

// File: tb/tb_interp_tile_scanner.sv
// tb_interp_tile_scanner: scoreboard bench; stimulus pushes expected pixels, a negedge monitor pops and compares on every accept.
module tb_interp_tile_scanner;
  localparam int W = 32, H = 32;
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [63:0] z;
    logic        last;
  } pix_t;
  logic clock = 1'b0, reset_n = 1'b0, bp = 1'b0;
  always #5 clock = ~clock;
  interp_tile_scanner_if sif();
  interp_tile_scanner #(.TILE_W(W), .TILE_H(H), .SETUP_CYCLES(4)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .scan(sif)
  );
  function automatic logic [63:0] zf(input logic [11:0] x, input logic [11:0] y);
    return {x, y, 8'hA5, x ^ y, 20'hC3C3C};
  endfunction
  assign sif.interp_in = zf(sif.x_ps, sif.y_ps);
  pix_t exp_q[$];
  pix_t prev_pix, cur;
  int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, done_cnt = 0;
  int rise_cyc = 0, done_cyc = 0, last_acc_cyc = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [140:0] got, input logic [140:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  always @(negedge clock) if (reset_n) begin
    cur = {sif.pix_x, sif.pix_y, sif.pix_z, sif.pix_last};
    if (sif.pix_valid && !prev_valid) rise_cyc = cyc;
    if (prev_stall) chk("stall_hold", {sif.pix_valid, cur}, {1'b1, prev_pix});
    if (sif.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sif.pix_valid && sif.pix_ready) begin
      acc_cnt++;
      if (sif.pix_last) last_acc_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_pix got=%0h exp=none", cur);
      end else chk("pix", cur, exp_q.pop_front());
    end
    prev_stall = sif.pix_valid && !sif.pix_ready;
    prev_pix   = cur;
    prev_valid = sif.pix_valid;
  end
  task automatic tick();
    @(posedge clock);
    #1;
    if (bp) sif.pix_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic push_tile(input int ox, input int oy, input int bx0, input int bx1,
                           input int by0, input int by1, output int n);
    pix_t p;
    n = 0;
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++)
        if (ox + i >= bx0 && ox + i <= bx1 && oy + j >= by0 && oy + j <= by1) begin
          p.x    = 12'(ox + i);
          p.y    = 12'(oy + j);
          p.z    = zf(p.x, p.y);
          p.last = 1'b0;
          exp_q.push_back(p);
          n++;
        end
    if (n > 0) begin
      p      = exp_q.pop_back();
      p.last = 1'b1;
      exp_q.push_back(p);
    end
  endtask
  task automatic begin_tile(input int ox, input int oy, input int bx0, input int bx1,
                            input int by0, input int by1, output int n, output int cs);
    push_tile(ox, oy, bx0, bx1, by0, by1, n);
    sif.tile_x = 12'(ox);
    sif.tile_y = 12'(oy);
`ifdef INTERP_SCAN_BBOX_EN
    sif.bbox_x0 = 12'(bx0);
    sif.bbox_x1 = 12'(bx1);
    sif.bbox_y0 = 12'(by0);
    sif.bbox_y1 = 12'(by1);
`endif
    sif.start = 1'b1;
    cs = cyc;
    tick();
    sif.start = 1'b0;
  endtask
  task automatic run_tile(input int ox, input int oy, input int bx0, input int bx1,
                          input int by0, input int by1);
    int n, cs, a0, d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    begin_tile(ox, oy, bx0, bx1, by0, by1, n, cs);
    chk("setup_pulse", {sif.setup, sif.busy}, 2'b11);
    tick();
    chk("setup_low", sif.setup, 0);
    for (int k = 0; k < 6000 && done_cnt == d0; k++) tick();
    repeat (3) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("pix_count", acc_cnt - a0, n);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_end", {sif.busy, sif.pix_valid}, 0);
    if (n > 0) begin
      chk("first_lat", rise_cyc - cs, 6);
      chk("done_lat", done_cyc - last_acc_cyc, 1);
    end else chk("empty_done_lat", done_cyc - cs, 5);
  endtask
  int n, cs, a0, d0;
`ifdef INTERP_SCAN_BBOX_EN
  localparam int BMAX = 4095;
`else
  localparam int BMAX = 1 << 20;
`endif
  initial begin
    sif.start     = 1'b1;
    sif.abort     = 1'b0;
    sif.tile_x    = 12'd0;
    sif.tile_y    = 12'd0;
    sif.pix_ready = 1'b1;
`ifdef INTERP_SCAN_BBOX_EN
    sif.bbox_x0 = 12'd0;
    sif.bbox_x1 = 12'd0;
    sif.bbox_y0 = 12'd0;
    sif.bbox_y1 = 12'd0;
`endif
    tick();
    tick();
    chk("rst_ctrl", {sif.busy, sif.setup, sif.pix_valid, sif.pix_last, sif.done}, 0);
    chk("rst_ps", {sif.x_ps, sif.y_ps}, 0);
    chk("rst_pix", {sif.pix_x, sif.pix_y, sif.pix_z}, 0);
    sif.start = 1'b0;
    reset_n   = 1'b1;
    tick();
    chk("idle_after_rst", {sif.busy, sif.done}, 0);
    run_tile(64, 32, 0, BMAX, 0, BMAX);
    bp = 1'b1;
    run_tile(128, 64, 0, BMAX, 0, BMAX);
    bp = 1'b0;
    sif.pix_ready = 1'b1;
    run_tile(4080, 4090, 0, BMAX, 0, BMAX);
    a0 = acc_cnt;
    d0 = done_cnt;
    begin_tile(64, 32, 0, BMAX, 0, BMAX, n, cs);
    repeat (105) tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    chk("abort_idle", {sif.busy, sif.pix_valid, sif.pix_last}, 0);
    exp_q.delete();
    repeat (10) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_pix_count", acc_cnt - a0, 101);
    run_tile(64, 32, 0, BMAX, 0, BMAX);
`ifdef INTERP_SCAN_BBOX_EN
    run_tile(64, 32, 70, 72, 40, 41);
    run_tile(64, 32, 200, 210, 40, 41);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
